// File: rtl/ram_async_read_if.sv
// Shared address/data bus for the async-read data RAM.
// The master drives address, write data and enable; the slave returns read data.
interface ram_async_read_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              we;
    logic [DATA_W-1:0] data_out;

    modport master (
        output addr,
        output data_in,
        output we,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  we,
        output data_out
    );
endinterface

// File: rtl/ram_async_read.sv
// Single-port RAM: synchronous write, combinational read, async clear on rst.
// Optional macro RAM_WR_BYPASS_EN forwards write data to data_out while we=1.
module ram_async_read #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    ram_async_read_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_rd;

    // Reset wins over a write on the same edge; an unknown we takes the else path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (bus.we) begin
            r_mem[bus.addr] <= bus.data_in;
        end
    end

    assign w_rd = r_mem[bus.addr];

`ifdef RAM_WR_BYPASS_EN
    assign bus.data_out = (bus.we && !rst) ? bus.data_in : w_rd;
`else
    assign bus.data_out = w_rd;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && $isunknown(bus.we))
            $warning("ram_async_read: we unknown at clock edge, write skipped");
    end
`endif
endmodule

// File: tb/tb_ram_async_read.sv
// Randomized scoreboard bench for ram_async_read against a byte-array model.
// Build with +define+RAM_WR_BYPASS_EN to exercise the bypass expectations.
module tb_ram_async_read;
    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample = 1'b0;
    int   passed = 0;
    int   total = 0;
    exp_t sb[$];
    logic [7:0] model [32];

    ram_async_read_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    ram_async_read #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: pops an expectation whenever the stimulus presents a read.
    always @(posedge sample) begin
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL monitor: got %02h with no expected value queued",
                     bus.data_out);
        end else begin
            e = sb.pop_front();
            if (bus.data_out === e.exp)
                passed++;
            else
                $display("FAIL %s: got %02h expected %02h",
                         e.name, bus.data_out, e.exp);
        end
    end

    task automatic rd(input logic [4:0] a, input logic [7:0] e,
                      input string n);
        bus.addr = a;
        #1;
        sb.push_back('{exp: e, name: n});
        sample = 1'b1;
        #1;
        sample = 1'b0;
    endtask

    // Reference rule: a write lands only when we=1 and rst=0 at the edge.
    task automatic edge_commit();
        @(posedge clk);
        if (rst)
            foreach (model[i]) model[i] = 8'h00;
        else if (bus.we)
            model[bus.addr] = bus.data_in;
    endtask

    function automatic logic [7:0] pre_edge(input logic [4:0] a);
`ifdef RAM_WR_BYPASS_EN
        if (bus.we && !rst)
            return bus.data_in;
`endif
        return model[a];
    endfunction

    initial begin
        logic [4:0] a;
        logic [7:0] d;
        foreach (model[i]) model[i] = 8'h00;
        bus.addr = '0;
        bus.data_in = '0;
        bus.we = 1'b0;

        rd(5'd0, 8'h00, "reset_hold_addr0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++)
            rd(5'(i), 8'h00, "init_sweep");

        @(negedge clk);
        bus.addr = 5'd1;
        bus.data_in = 8'hAA;
        bus.we = 1'b1;
        edge_commit();
        @(negedge clk);
        bus.we = 1'b0;
        rd(5'd1, 8'hAA, "write_addr1");
        rd(5'd0, 8'h00, "iso_addr0");
        rd(5'd1, 8'hAA, "iso_addr1");

        @(negedge clk);
        bus.addr = 5'd2;
        bus.data_in = 8'h55;
        bus.we = 1'b0;
        edge_commit();
        edge_commit();
        @(negedge clk);
        rd(5'd2, 8'h00, "we0_no_write");

        @(negedge clk);
        bus.data_in = 8'h3C;
        bus.we = 1'b1;
        rd(5'd3, pre_edge(5'd3), "rdw_before_edge");
        edge_commit();
        #1;
        rd(5'd3, 8'h3C, "rdw_after_edge");
        bus.we = 1'b0;

        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            a = 5'($urandom_range(31));
            d = 8'($urandom);
            bus.data_in = d;
            bus.we = 1'($urandom_range(1));
            rd(a, pre_edge(a), "rand_pre_edge");
            edge_commit();
            #1;
            rd(a, model[a], "rand_post_edge");
            bus.we = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            a = 5'($urandom_range(31));
            rd(a, model[a], "rand_read");
        end

        @(negedge clk);
        bus.addr = 5'd31;
        bus.data_in = 8'hFF;
        bus.we = 1'b1;
        edge_commit();
        @(negedge clk);
        bus.we = 1'b0;
        rd(5'd31, 8'hFF, "write_addr31");
        rst = 1'b1;
        foreach (model[i]) model[i] = 8'h00;
        rd(5'd31, 8'h00, "async_rst_addr31");
        rd(5'd1, 8'h00, "async_rst_addr1");

        @(negedge clk);
        bus.addr = 5'd5;
        bus.data_in = 8'h77;
        bus.we = 1'b1;
        edge_commit();
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b0;
        rd(5'd5, 8'h00, "rst_beats_write");
        for (int i = 0; i < 32; i++)
            rd(5'(i), model[i], "post_rst_sweep");

        #5;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
